seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_det_sat_cnt.sv | 24 ++
 rtl/seq_detect_param.sv | 100 ++++++++++
 tb/tb_seq_detect_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parameterised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    HIT   = 2'd2
  } state_t;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter with synchronous clear; a same-cycle increment wins over the clear, giving 1.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime pattern/length/overlap configuration.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_bit,
  input  logic                        cfg_we,
  input  logic [MAX_LEN-1:0]          cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        cnt_clr,
  output logic                        match,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        armed
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] mask_c;
  logic [MAX_LEN-1:0] hist_nxt_c;
  logic [LEN_W-1:0]   fill_nxt_c;
  logic               accept_c;
  logic               hit_c;
  logic               len_ok_c;

  // Candidate history/fill for an accepted bit and the hit decision on them.
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(len));
    end
    accept_c   = in_valid && !cfg_we && (state != UNCFG);
    hist_nxt_c = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt_c = (fill < len) ? fill + LEN_W'(1) : len;
    hit_c      = accept_c && (fill_nxt_c >= len) &&
                 (((hist_nxt_c ^ pat) & mask_c) == '0);
    len_ok_c   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  // Detector FSM; match/armed are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNCFG;
      pat   <= '0;
      len   <= '0;
      ovl   <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      armed <= 1'b0;
    end else if (cfg_we) begin
      pat   <= cfg_pattern;
      len   <= cfg_len;
      ovl   <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      state <= len_ok_c ? HUNT : UNCFG;
      match <= 1'b0;
      armed <= len_ok_c;
    end else if (state != UNCFG) begin
      if (accept_c) begin
        hist <= hist_nxt_c;
        fill <= (hit_c && !ovl) ? '0 : fill_nxt_c;
      end
      state <= hit_c ? HIT : HUNT;
      match <= hit_c;
      armed <= 1'b1;
    end
  end

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit_c),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed, table-driven bench for seq_detect_param (default and small-counter instances).
module tb_seq_detect_param;

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       b;
    logic       clr;
    logic       m;
    logic       a;
    int         n;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       in_valid = 1'b0, in_bit = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       match, armed;
  logic [7:0] match_cnt;

  logic       in_valid2 = 1'b0, in_bit2 = 1'b0, cfg_we2 = 1'b0, cfg_overlap2 = 1'b0, cnt_clr2 = 1'b0;
  logic [3:0] cfg_pattern2 = '0;
  logic [2:0] cfg_len2 = '0;
  logic       match2, armed2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detect_param #(.MAX_LEN(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_bit(in_bit2), .cfg_we(cfg_we2),
    .cfg_pattern(cfg_pattern2), .cfg_len(cfg_len2), .cfg_overlap(cfg_overlap2),
    .cnt_clr(cnt_clr2), .match(match2), .match_cnt(match_cnt2), .armed(armed2)
  );

  // Expected counter value given the model count (counter absent -> always 0).
  function automatic int ec(input int n);
`ifdef SEQ_DET_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] pat, input logic [3:0] len,
                              input logic ov, input logic v, input logic b, input logic clr,
                              input logic m, input logic a, input int n);
    vec_t r;
    r.we = we; r.pat = pat; r.len = len; r.ov = ov; r.v = v; r.b = b; r.clr = clr;
    r.m = m; r.a = a; r.n = n;
    return r;
  endfunction

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic a, input int n);
    tbl.push_back(mk(1'b1, p, l, o, 1'b0, 1'b0, 1'b0, 1'b0, a, n));
  endtask

  task automatic bt(input logic v, input logic b, input logic m, input logic a, input int n);
    tbl.push_back(mk(1'b0, '0, '0, 1'b0, v, b, 1'b0, m, a, n));
  endtask

  task automatic step(input logic we, input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b, input logic clr);
    cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = v; in_bit = b; cnt_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic we, input logic [3:0] p, input logic [2:0] l, input logic o,
                       input logic v, input logic b, input logic clr);
    cfg_we2 = we; cfg_pattern2 = p; cfg_len2 = l; cfg_overlap2 = o;
    in_valid2 = v; in_bit2 = b; cnt_clr2 = clr;
    @(posedge clk); #1;
  endtask

  task automatic chk2(input string name, input logic m, input logic a, input int n);
    chk({name, ".match"}, int'(match2), int'(m));
    chk({name, ".armed"}, int'(armed2), int'(a));
    chk({name, ".cnt"}, int'(match_cnt2), ec(n));
  endtask

  initial begin
    // 1110, len 4, non-overlap
    cfg(8'b1110, 4'd4, 1'b0, 1'b1, 0);
    bt(1,1, 0,1,0); bt(1,1, 0,1,0); bt(1,1, 0,1,0); bt(1,0, 1,1,1); bt(0,0, 0,1,1);
    // 101 overlapping: hits after bits 3 and 5
    cfg(8'b101, 4'd3, 1'b1, 1'b1, 1);
    bt(1,1, 0,1,1); bt(1,0, 0,1,1); bt(1,1, 1,1,2); bt(1,0, 0,1,2); bt(1,1, 1,1,3);
    // 101 non-overlapping: single hit
    cfg(8'b101, 4'd3, 1'b0, 1'b1, 3);
    bt(1,1, 0,1,3); bt(1,0, 0,1,3); bt(1,1, 1,1,4); bt(1,0, 0,1,4); bt(1,1, 0,1,4);
    // 1110 with idle cycles between bits
    cfg(8'b1110, 4'd4, 1'b0, 1'b1, 4);
    bt(1,1, 0,1,4); bt(0,1, 0,1,4); bt(1,1, 0,1,4); bt(0,1, 0,1,4);
    bt(1,1, 0,1,4); bt(0,0, 0,1,4); bt(1,0, 1,1,5); bt(0,0, 0,1,5);
    // 11 overlapping: back-to-back hits keep match high
    cfg(8'b11, 4'd2, 1'b1, 1'b1, 5);
    bt(1,1, 0,1,5); bt(1,1, 1,1,6); bt(1,1, 1,1,7); bt(0,0, 0,1,7);
    // reconfigure with in_valid in same cycle: bit dropped, history cleared
    cfg(8'b1110, 4'd4, 1'b0, 1'b1, 7);
    bt(1,1, 0,1,7); bt(1,1, 0,1,7); bt(1,1, 0,1,7);
    tbl.push_back(mk(1'b1, 8'b1110, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7));
    bt(1,0, 0,1,7);
    // full-length pattern
    cfg(8'hA5, 4'd8, 1'b0, 1'b1, 7);
    bt(1,1, 0,1,7); bt(1,0, 0,1,7); bt(1,1, 0,1,7); bt(1,0, 0,1,7);
    bt(1,0, 0,1,7); bt(1,1, 0,1,7); bt(1,0, 0,1,7); bt(1,1, 1,1,8);
    // clear counter without hit
    tbl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0));
    // invalid lengths leave the detector unarmed
    cfg(8'b1, 4'd0, 1'b1, 1'b0, 0);
    bt(1,1, 0,0,0); bt(1,1, 0,0,0);
    cfg(8'b1110, 4'd9, 1'b0, 1'b0, 0);
    bt(1,1, 0,0,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.match", int'(match), 0);
    chk("reset.armed", int'(armed), 0);
    chk("reset.cnt", int'(match_cnt), 0);
    chk("reset2.armed", int'(armed2), 0);
    rst = 1'b1;
    step(0, '0, '0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ov, tbl[i].v, tbl[i].b, tbl[i].clr);
      chk($sformatf("row%0d.match", i), int'(match), int'(tbl[i].m));
      chk($sformatf("row%0d.armed", i), int'(armed), int'(tbl[i].a));
      chk($sformatf("row%0d.cnt", i), int'(match_cnt), ec(tbl[i].n));
    end
    step(0, '0, '0, 0, 0, 0, 0);

    // small counter: len-1 pattern, five hits saturate at 3
    step2(1, 4'b0001, 3'd1, 1, 0, 0, 0); chk2("c2.cfg", 0, 1, 0);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.h1", 1, 1, 1);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.h2", 1, 1, 2);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.h3", 1, 1, 3);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.h4", 1, 1, 3);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.h5", 1, 1, 3);
    step2(0, '0, '0, 0, 1, 1, 1); chk2("c2.clr_hit", 1, 1, 1);
    step2(0, '0, '0, 0, 0, 1, 1); chk2("c2.clr", 0, 1, 0);
    step2(0, '0, '0, 0, 1, 0, 0); chk2("c2.miss", 0, 1, 0);
    step2(1, 4'b0001, 3'd0, 1, 0, 0, 0); chk2("c2.len0", 0, 0, 0);
    step2(0, '0, '0, 0, 1, 1, 0); chk2("c2.len0_bit", 0, 0, 0);
    step2(1, 4'b0001, 3'd5, 1, 0, 0, 0); chk2("c2.len5", 0, 0, 0);
    step2(0, '0, '0, 0, 0, 0, 0);

    // asynchronous reset mid-sequence discards history
    step(1, 8'b1110, 4'd4, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    step(0, '0, '0, 0, 1, 1, 0);
    chk("rst.pre_armed", int'(armed), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst.match", int'(match), 0);
    chk("rst.armed", int'(armed), 0);
    chk("rst.cnt", int'(match_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, '0, '0, 0, 1, 0, 0);
    chk("rst.bit0_match", int'(match), 0);
    chk("rst.bit0_armed", int'(armed), 0);
    step(1, 8'b1110, 4'd4, 0, 0, 0, 0);
    step(0, '0, '0, 0, 1, 0, 0);
    chk("rst.recfg_match", int'(match), 0);
    chk("rst.recfg_armed", int'(armed), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
